// File: rtl/rr_mux_arbiter_4.sv
// rr_mux_arbiter_4: round-robin 4:1 valid/ready arbiter with atomic bursts and a one-entry output buffer.
module rr_mux_arbiter_4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  input  logic [3:0]         req_last,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic [1:0]         out_sel,
  output logic [3:0]         grant
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d, sel_q, sel_d, pick;
  logic [3:0]       grant_q, grant_d;
  logic             ov_q, ov_d, ol_q, ol_d, buf_free, accept;
  logic [WIDTH-1:0] od_q, od_d;

  // Descending scan so the requester closest to ptr wins.
  always_comb begin
    pick = ptr_q;
    for (int i = 3; i >= 0; i--)
      if (req_valid[ptr_q + 2'(i)]) pick = ptr_q + 2'(i);
  end

  assign buf_free  = !ov_q || out_ready;
  assign req_ready = (state_q == LOCKED && buf_free) ? 4'b0001 << sel_q : 4'b0000;
  assign accept    = state_q == LOCKED && buf_free && req_valid[sel_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    if (state_q == IDLE && |req_valid) begin
      state_d = LOCKED;
      sel_d   = pick;
      ptr_d   = pick + 2'd1;
      grant_d = 4'b0001 << pick;
    end
    if (accept && req_last[sel_q]) begin
      state_d = IDLE;
      grant_d = 4'b0000;
    end
  end

  assign ov_d = accept || (ov_q && !out_ready);
  assign od_d = accept ? req_data[sel_q*WIDTH +: WIDTH] : od_q;
  assign ol_d = accept ? req_last[sel_q] : ol_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_last  = ol_q;
  assign out_sel   = sel_q;
  assign grant     = grant_q;
endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// tb_rr_mux_arbiter_4: directed cycle checks plus a beat scoreboard drained by an output monitor.
module tb_rr_mux_arbiter_4;
  logic        clk = 1'b0, rst_n = 1'b0, out_ready = 1'b1;
  logic [3:0]  req_valid = '0, req_last = '0, req_ready, grant;
  logic [15:0] req_data = '0;
  logic        out_valid, out_last;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic [4:0]  sb[$];
  logic [4:0]  exp_beat;
  int          checks = 0, errors = 0;

  rr_mux_arbiter_4 #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .out_sel(out_sel), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Every beat that completes an output handshake must match the scoreboard head.
  initial forever begin
    @(negedge clk);
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat: got %0h expected no beat at %0t", {out_last, out_data}, $time);
      end else begin
        exp_beat = sb.pop_front();
        chk("beat", 32'({out_last, out_data}), 32'(exp_beat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    req_valid = 4'hF; req_data = 16'h4321; req_last = 4'hF;
    repeat (2) begin
      nxt(); #1;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_sel", 32'(out_sel), 0);
    end
    sb.push_back(5'h11); sb.push_back(5'h12); sb.push_back(5'h13);
    sb.push_back(5'h14); sb.push_back(5'h11);
    nxt(); rst_n = 1'b1; #1;
    chk("idle_ready", 32'(req_ready), 0);
    for (int c = 1; c <= 9; c++) begin
      nxt(); #1;
      if (c % 2 == 1) begin
        chk("fair_grant", 32'(grant), 32'(4'b0001 << ((c - 1) / 2 % 4)));
        chk("fair_ready", 32'(req_ready), 32'(4'b0001 << ((c - 1) / 2 % 4)));
      end else begin
        chk("fair_gap_grant", 32'(grant), 0);
        chk("fair_gap_ready", 32'(req_ready), 0);
      end
    end
    nxt(); req_valid = 4'h0; #1;

    sb.push_back(5'h1A);
    nxt(); req_valid = 4'b0100; req_data = 16'h0A00; req_last = 4'b0100; #1;
    chk("single_idle_ready", 32'(req_ready), 0);
    nxt(); #1;
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_ready", 32'(req_ready), 32'h4);
    nxt(); req_valid = 4'h0; #1;
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data", 32'(out_data), 32'hA);
    chk("single_last", 32'(out_last), 1);
    chk("single_sel", 32'(out_sel), 2);
    chk("single_grant_off", 32'(grant), 0);

    sb.push_back(5'h05); sb.push_back(5'h06); sb.push_back(5'h17); sb.push_back(5'h19);
    nxt(); req_valid = 4'b0010; req_data = 16'h0050; req_last = 4'b0000; #1;
    nxt(); req_valid = 4'b0011; req_data = 16'h0059; req_last = 4'b0001; #1;
    chk("lock_grant", 32'(grant), 32'h2);
    chk("lock_ready", 32'(req_ready), 32'h2);
    nxt(); req_data = 16'h0069; #1;
    chk("lock_data1", 32'(out_data), 32'h5);
    chk("lock_sel1", 32'(out_sel), 1);
    chk("lock_ready1", 32'(req_ready), 32'h2);
    chk("lock_grant1", 32'(grant), 32'h2);
    nxt(); req_data = 16'h0079; req_last = 4'b0011; #1;
    chk("lock_data2", 32'(out_data), 32'h6);
    chk("lock_sel2", 32'(out_sel), 1);
    chk("lock_ready2", 32'(req_ready), 32'h2);
    nxt(); req_valid = 4'b0001; #1;
    chk("lock_data3", 32'(out_data), 32'h7);
    chk("lock_last3", 32'(out_last), 1);
    chk("lock_sel3", 32'(out_sel), 1);
    chk("lock_release", 32'(grant), 0);
    chk("lock_bubble_ready", 32'(req_ready), 0);
    nxt(); #1;
    chk("lock_next_grant", 32'(grant), 32'h1);
    nxt(); req_valid = 4'h0; #1;
    chk("lock_next_data", 32'(out_data), 32'h9);

    sb.push_back(5'h0B); sb.push_back(5'h0C); sb.push_back(5'h1D);
    nxt(); req_valid = 4'b1000; req_data = 16'hB000; req_last = 4'b0000; #1;
    nxt(); #1;
    chk("bp_grant", 32'(grant), 32'h8);
    chk("bp_ready", 32'(req_ready), 32'h8);
    nxt(); out_ready = 1'b0; req_data = 16'hC000; #1;
    chk("bp_hold_data", 32'(out_data), 32'hB);
    chk("bp_hold_ready", 32'(req_ready), 0);
    repeat (2) begin
      nxt(); #1;
      chk("bp_hold_data", 32'(out_data), 32'hB);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_ready", 32'(req_ready), 0);
    end
    nxt(); out_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(req_ready), 32'h8);
    nxt(); req_data = 16'hD000; req_last = 4'b1000; #1;
    chk("bp_data_c", 32'(out_data), 32'hC);
    nxt(); req_valid = 4'h0; #1;
    chk("bp_data_d", 32'(out_data), 32'hD);
    chk("bp_grant_off", 32'(grant), 0);

    sb.push_back(5'h0E); sb.push_back(5'h0F); sb.push_back(5'h11);
    nxt(); req_valid = 4'b0100; req_data = 16'h0E00; req_last = 4'b0000; #1;
    nxt(); #1;
    chk("mrst_grant", 32'(grant), 32'h4);
    nxt(); req_data = 16'h0F00; #1;
    chk("mrst_data1", 32'(out_data), 32'hE);
    nxt(); rst_n = 1'b0; #1;
    chk("mrst_data2", 32'(out_data), 32'hF);
    nxt(); rst_n = 1'b1; req_valid = 4'hF; req_data = 16'h4321; req_last = 4'hF; #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    chk("mrst_grant_off", 32'(grant), 0);
    chk("mrst_ready", 32'(req_ready), 0);
    nxt(); #1;
    chk("mrst_restart_grant", 32'(grant), 32'h1);
    chk("mrst_restart_sel", 32'(out_sel), 0);
    nxt(); req_valid = 4'h0; #1;
    chk("mrst_restart_data", 32'(out_data), 32'h1);

    repeat (3) nxt();
    #1;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
